ram_req_ctrl: RTL and testbench

- Request front-end that sits directly upstream of the single-port flip-flop RAM (PORT=1) and drives its en/rw_/addr/wdata port.
- Converts a valid/ready request stream (read or byte-masked write) into RAM accesses.
- Captures RAM read data at the correct latency for either OUTREG setting into a response FIFO exposed as a valid/ready stream.
- Credit-based admission guarantees no read data is ever dropped under response backpressure.

---
 rtl/ram_req_ctrl.sv | 134 +++++++++++++
 tb/tb_ram_req_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl
//   Request front-end for a single-port flip-flop RAM. Turns a valid/ready
//   request stream (reads, byte-masked writes) into RAM port accesses and
//   returns read data through a small response FIFO. A read is admitted only
//   when a FIFO slot is guaranteed for it, so responses are never dropped
//   under backpressure.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (accept = valid && ready)
//   req_we, req_be             1 = write / byte enables (writes only)
//   req_addr, req_wdata        word address, write data
//   resp_valid/resp_ready      response handshake
//   resp_rdata                 response data (register driven)
//   ram_en, ram_rw_            RAM byte enables, 1 = read / 0 = write
//   ram_addr, ram_wdata        RAM address and write data
//   ram_rdata                  RAM read data (latency set by OUTREG)
module ram_req_ctrl #(
  parameter int DATA       = 32,
  parameter int BYTE       = DATA,
  parameter int DEPTH      = 4,
  parameter int OUTREG     = 0,
  parameter int RESP_DEPTH = 2,
  parameter int BYTESEL    = DATA / BYTE,
  parameter int ADDR       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [BYTESEL-1:0] req_be,
  input  logic [ADDR-1:0]    req_addr,
  input  logic [DATA-1:0]    req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA-1:0]    resp_rdata,
  output logic [BYTESEL-1:0] ram_en,
  output logic               ram_rw_,
  output logic [ADDR-1:0]    ram_addr,
  output logic [DATA-1:0]    ram_wdata,
  input  logic [DATA-1:0]    ram_rdata
);

  // Pointer is at least one bit wide; storage is sized to the full pointer
  // range so every pointer value indexes a real slot, even for RESP_DEPTH=1.
  localparam int PW    = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int SLOTS = 1 << PW;
  localparam int CW    = $clog2(RESP_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(RESP_DEPTH - 1);
  localparam logic [CW:0]   CREDITS  = (CW + 1)'(RESP_DEPTH);

  logic            accept;
  logic            rd_accept;
  logic            push;
  logic            pop;
  logic [CW:0]     used;

  logic            inflight_q, inflight_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DATA-1:0] fifo_q [SLOTS];
  logic [DATA-1:0] fifo_d [SLOTS];

  // Credits cover both queued entries and a read whose data is still in the
  // RAM output register, so a slot always exists when that data lands.
  assign used       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign req_ready  = !reset && (used < CREDITS);
  assign accept     = req_valid && req_ready;
  assign rd_accept  = accept && !req_we;
  assign push       = (OUTREG != 0) ? inflight_q : rd_accept;
  assign pop        = resp_valid && resp_ready;
  assign resp_valid = (count_q != '0);
  assign resp_rdata = fifo_q[rptr_q];

  always_comb begin
    ram_en    = '0;
    ram_rw_   = 1'b1;
    ram_addr  = '0;
    ram_wdata = '0;
    if (accept) begin
      ram_addr = req_addr;
      if (req_we) begin
        ram_en    = req_be;
        ram_rw_   = 1'b0;
        ram_wdata = req_wdata;
      end else begin
        ram_en = '1;
      end
    end
  end

  always_comb begin
    inflight_d = (OUTREG != 0) && rd_accept;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    fifo_d     = fifo_q;
    if (push) begin
      fifo_d[wptr_q] = ram_rdata;
      wptr_d         = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      for (int i = 0; i < SLOTS; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb_ram_req_ctrl
//   Three controller instances share one stimulus stream:
//     inst0: OUTREG=0, RESP_DEPTH=2   inst1: OUTREG=1, RESP_DEPTH=2
//     inst2: OUTREG=0, RESP_DEPTH=1
//   Each drives its own behavioural RAM. A queue-based reference model per
//   instance predicts readiness, RAM drive and response stream every cycle.
module tb_ram_req_ctrl;
  localparam int NI = 3;
  localparam int K_OR  [NI] = '{0, 1, 0};
  localparam int K_DEP [NI] = '{2, 2, 1};

  typedef struct {
    logic [31:0] data;
    int          vis;
  } resp_t;

  typedef struct {
    bit          v;
    bit          we;
    logic [3:0]  be;
    logic [1:0]  a;
    logic [31:0] d;
    bit          rr;
    bit          e_rdy;
    bit          e_rv;
    logic [31:0] e_rd;
    logic [3:0]  e_en;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, resp_ready;
  logic [3:0]  req_be;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;

  logic        rdy_w  [NI];
  logic        rv_w   [NI];
  logic [31:0] rd_w   [NI];
  logic [3:0]  en_w   [NI];
  logic        rw_w   [NI];
  logic [1:0]  addr_w [NI];
  logic [31:0] wd_w   [NI];
  logic [31:0] rin_w  [NI];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 1'b0;
  bit prev_reset = 1'b0;

  resp_t       exp_q [NI][$];
  logic [31:0] mmem  [NI][4];
  logic [31:0] popped1 [$];

  logic        s_rdy [NI];
  logic        s_rv  [NI];
  logic [31:0] s_rd  [NI];
  logic [3:0]  s_en  [NI];
  bit          s_acc1;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int OR = (g == 1) ? 1 : 0;
    localparam int RD = (g == 2) ? 1 : 2;
    logic [31:0] ram_mem [4];
    logic [31:0] rd_reg;

    ram_req_ctrl #(.DATA(32), .BYTE(8), .DEPTH(4), .OUTREG(OR), .RESP_DEPTH(RD)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(rdy_w[g]), .req_we(req_we), .req_be(req_be),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv_w[g]), .resp_ready(resp_ready), .resp_rdata(rd_w[g]),
      .ram_en(en_w[g]), .ram_rw_(rw_w[g]), .ram_addr(addr_w[g]), .ram_wdata(wd_w[g]),
      .ram_rdata(rin_w[g])
    );

    always @(posedge clk) begin
      if (!rw_w[g]) begin
        for (int b = 0; b < 4; b++)
          if (en_w[g][b]) ram_mem[addr_w[g]][8*b +: 8] <= wd_w[g][8*b +: 8];
      end else if (|en_w[g]) begin
        rd_reg <= ram_mem[addr_w[g]];
      end
    end
    assign rin_w[g] = (OR != 0) ? rd_reg : ram_mem[addr_w[g]];

    always @(negedge clk) begin
      if (armed) begin
        checks++;
        if (!reset && dut.push && (32'(dut.count_q) >= RD)) begin
          errors++;
          $display("FAIL push_while_full inst%0d cyc=%0d got=push want=no_push", g, cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d got=0x%0h want=0x%0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    s_acc1 = req_valid && rdy_w[1];
    for (int k = 0; k < NI; k++) begin
      bit          e_rdy, e_rv, acc;
      logic [3:0]  e_en;
      logic        e_rw;
      logic [1:0]  e_a;
      logic [31:0] e_wd;
      s_rdy[k] = rdy_w[k];
      s_rv[k]  = rv_w[k];
      s_rd[k]  = rd_w[k];
      s_en[k]  = en_w[k];
      e_rdy = !reset && (exp_q[k].size() < K_DEP[k]);
      e_rv  = (exp_q[k].size() != 0) && (exp_q[k][0].vis <= cyc);
      chk("req_ready", k, 32'(rdy_w[k]), 32'(e_rdy));
      chk("resp_valid", k, 32'(rv_w[k]), 32'(e_rv));
      if (e_rv) chk("resp_rdata", k, rd_w[k], exp_q[k][0].data);
      if (prev_reset) chk("rdata_after_reset", k, rd_w[k], 32'h0);
      acc  = req_valid && e_rdy;
      e_en = 4'h0;
      e_rw = 1'b1;
      e_a  = 2'd0;
      e_wd = 32'h0;
      if (acc) begin
        e_a = req_addr;
        if (req_we) begin
          e_en = req_be;
          e_rw = 1'b0;
          e_wd = req_wdata;
        end else begin
          e_en = 4'hF;
        end
      end
      chk("ram_en", k, 32'(en_w[k]), 32'(e_en));
      chk("ram_rw_", k, 32'(rw_w[k]), 32'(e_rw));
      chk("ram_addr", k, 32'(addr_w[k]), 32'(e_a));
      if (!(acc && !req_we)) chk("ram_wdata", k, wd_w[k], e_wd);
      if (reset) begin
        exp_q[k].delete();
      end else begin
        if (e_rv && resp_ready) void'(exp_q[k].pop_front());
        if (acc && !req_we) exp_q[k].push_back('{mmem[k][req_addr], cyc + 1 + K_OR[k]});
        if (acc && req_we)
          for (int b = 0; b < 4; b++)
            if (req_be[b]) mmem[k][req_addr][8*b +: 8] = req_wdata[8*b +: 8];
      end
    end
    if (!reset && rv_w[1] && resp_ready) popped1.push_back(rd_w[1]);
    prev_reset = reset;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit we, input logic [3:0] be, input logic [1:0] a,
                       input logic [31:0] d, input bit rr);
    req_valid  = v;
    req_we     = we;
    req_be     = be;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = rr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 4'h0, 2'd0, 32'h0, 1'b1);
      tick();
    end
  endtask

  function automatic vec_t mk(bit v, bit we, logic [3:0] be, logic [1:0] a, logic [31:0] d, bit rr,
                              bit e_rdy, bit e_rv, logic [31:0] e_rd, logic [3:0] e_en);
    vec_t r;
    r.v = v; r.we = we; r.be = be; r.a = a; r.d = d; r.rr = rr;
    r.e_rdy = e_rdy; r.e_rv = e_rv; r.e_rd = e_rd; r.e_en = e_en;
    return r;
  endfunction

  vec_t tbl [19];
  int   idx;

  initial begin
    // Expectations below are for inst0 (OUTREG=0, RESP_DEPTH=2).
    tbl[0]  = mk(1, 1, 4'hF, 2'd0, 32'h0,        1, 1, 0, 32'h0,        4'hF);
    tbl[1]  = mk(1, 1, 4'hF, 2'd1, 32'h0,        1, 1, 0, 32'h0,        4'hF);
    tbl[2]  = mk(1, 1, 4'hF, 2'd2, 32'h0,        1, 1, 0, 32'h0,        4'hF);
    tbl[3]  = mk(1, 1, 4'hF, 2'd3, 32'h0,        1, 1, 0, 32'h0,        4'hF);
    tbl[4]  = mk(1, 1, 4'hF, 2'd2, 32'hDEADBEEF, 1, 1, 0, 32'h0,        4'hF);
    tbl[5]  = mk(1, 0, 4'h0, 2'd2, 32'h0,        1, 1, 0, 32'h0,        4'hF);
    tbl[6]  = mk(0, 0, 4'h0, 2'd0, 32'h0,        1, 1, 1, 32'hDEADBEEF, 4'h0);
    tbl[7]  = mk(1, 1, 4'hF, 2'd1, 32'h11223344, 1, 1, 0, 32'h0,        4'hF);
    tbl[8]  = mk(1, 1, 4'h2, 2'd1, 32'hAABBCCDD, 1, 1, 0, 32'h0,        4'h2);
    tbl[9]  = mk(1, 0, 4'h0, 2'd1, 32'h0,        1, 1, 0, 32'h0,        4'hF);
    tbl[10] = mk(0, 0, 4'h0, 2'd0, 32'h0,        1, 1, 1, 32'h1122CC44, 4'h0);
    tbl[11] = mk(1, 1, 4'h0, 2'd3, 32'h55,       1, 1, 0, 32'h0,        4'h0);
    tbl[12] = mk(1, 0, 4'h0, 2'd3, 32'h0,        0, 1, 0, 32'h0,        4'hF);
    tbl[13] = mk(1, 0, 4'h0, 2'd0, 32'h0,        0, 1, 1, 32'h0,        4'hF);
    tbl[14] = mk(1, 0, 4'h0, 2'd2, 32'h0,        0, 0, 1, 32'h0,        4'h0);
    tbl[15] = mk(1, 0, 4'h0, 2'd2, 32'h0,        1, 0, 1, 32'h0,        4'h0);
    tbl[16] = mk(1, 0, 4'h0, 2'd2, 32'h0,        1, 1, 1, 32'h0,        4'hF);
    tbl[17] = mk(0, 0, 4'h0, 2'd0, 32'h0,        1, 1, 1, 32'hDEADBEEF, 4'h0);
    tbl[18] = mk(0, 0, 4'h0, 2'd0, 32'h0,        1, 1, 0, 32'h0,        4'h0);

    reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 2'd0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    tick();
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].be, tbl[i].a, tbl[i].d, tbl[i].rr);
      tick();
      chk("tbl_ready", 0, 32'(s_rdy[0]), 32'(tbl[i].e_rdy));
      chk("tbl_valid", 0, 32'(s_rv[0]), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk("tbl_rdata", 0, s_rd[0], tbl[i].e_rd);
      chk("tbl_ram_en", 0, 32'(s_en[0]), 32'(tbl[i].e_en));
    end

    // Backpressure on inst1 (OUTREG=1, two credits): only two reads admitted.
    idle(6);
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 1'b1, 4'hF, 2'(j), 32'hA000_0000 + 32'(j), 1'b1);
      tick();
    end
    popped1.delete();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 4'h0, 2'(idx), 32'h0, 1'b0);
      tick();
      if (s_acc1) idx++;
    end
    chk("bp_accepted", 1, 32'(idx), 32'd2);
    chk("bp_ready_low", 1, 32'(s_rdy[1]), 32'd0);
    for (int c = 0; c < 40 && idx < 4; c++) begin
      drive(1'b1, 1'b0, 4'h0, 2'(idx), 32'h0, 1'b1);
      tick();
      if (s_acc1) idx++;
    end
    chk("bp_all_accepted", 1, 32'(idx), 32'd4);
    for (int c = 0; c < 20 && popped1.size() < 4; c++) idle(1);
    chk("bp_resp_count", 1, 32'(popped1.size()), 32'd4);
    for (int j = 0; j < 4; j++)
      if (j < popped1.size()) chk("bp_order", 1, popped1[j], 32'hA000_0000 + 32'(j));

    // Back-to-back reads on inst0: four consecutive responses, pointers wrap.
    idle(6);
    for (int t = 0; t < 6; t++) begin
      if (t < 4) drive(1'b1, 1'b0, 4'h0, 2'(t), 32'h0, 1'b1);
      else drive(1'b0, 1'b0, 4'h0, 2'd0, 32'h0, 1'b1);
      tick();
      if (t < 4) chk("b2b_ready", 0, 32'(s_rdy[0]), 32'd1);
      chk("b2b_valid", 0, 32'(s_rv[0]), 32'(t >= 1 && t <= 4));
      if (t >= 1 && t <= 4) chk("b2b_data", 0, s_rd[0], 32'hA000_0000 + 32'(t - 1));
    end

    // Reset with responses queued and a read in flight (inst1).
    idle(6);
    drive(1'b1, 1'b0, 4'h0, 2'd0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'h0, 2'd1, 32'h0, 1'b0);
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b0, 4'h0, 2'd2, 32'h0, 1'b0);
    tick();
    for (int k = 0; k < NI; k++) begin
      chk("rst_ready", k, 32'(s_rdy[k]), 32'd0);
      chk("rst_ram_en", k, 32'(s_en[k]), 32'd0);
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 2'd0, 32'h0, 1'b1);
    tick();
    for (int k = 0; k < NI; k++) begin
      chk("post_rst_valid", k, 32'(s_rv[k]), 32'd0);
      chk("post_rst_rdata", k, s_rd[k], 32'h0);
      chk("post_rst_ram_en", k, 32'(s_en[k]), 32'd0);
    end
    for (int c = 0; c < 4; c++) begin
      idle(1);
      chk("no_stale_resp", 1, 32'(s_rv[1]), 32'd0);
    end

    // Single-entry FIFO (inst2): simultaneous push/pop never admitted at full.
    drive(1'b1, 1'b0, 4'h0, 2'd2, 32'h0, 1'b1);
    tick();
    chk("d1_ready0", 2, 32'(s_rdy[2]), 32'd1);
    drive(1'b1, 1'b0, 4'h0, 2'd3, 32'h0, 1'b1);
    tick();
    chk("d1_ready_full", 2, 32'(s_rdy[2]), 32'd0);
    chk("d1_valid", 2, 32'(s_rv[2]), 32'd1);
    chk("d1_data", 2, s_rd[2], 32'hA000_0002);
    tick();
    chk("d1_ready_drained", 2, 32'(s_rdy[2]), 32'd1);
    idle(1);
    chk("d1_data2", 2, s_rd[2], 32'hA000_0003);

    // Randomized traffic with phases of heavy and light response backpressure.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom),
            $urandom, ((c / 300) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      tick();
    end
    reset = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
